// File: rtl/axi_rd_4_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_4_arbiter
//
// Purpose:
//   Four-master AXI read-channel arbiter. Masters a, b, c and d compete for a
//   single shared slave AR port under round-robin arbitration. Only one burst
//   is outstanding at a time. The R beats of that burst are steered back to
//   the master that won the grant.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   x_ar* (x = a,b,c,d)     master AR request channels (x_arready is an output)
//   x_r*  (x = a,b,c,d)     master R return channels (x_rready is an input)
//   ar*                     registered slave AR request (arready is an input)
//   r*                      slave R channel (rready is an output)
//   err_rlast               sticky flag: rlast placement or rid did not match
//                           the burst that was issued
//   gnt                     index of the current or most recent grant
//                           (0 = a .. 3 = d)
// ---------------------------------------------------------------------------
module axi_rd_4_arbiter #(
   parameter int AWID   = 32,
   parameter int EXTRAS = 8,
   parameter int IDWID  = 4,
   parameter int DWID   = 64
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic [IDWID-1:0]  a_arid,
   input  logic [AWID-1:0]   a_araddr,
   input  logic [7:0]        a_arlen,
   input  logic [2:0]        a_arsize,
   input  logic [EXTRAS-1:0] a_arextras,
   input  logic [1:0]        a_arburst,
   input  logic              a_arvalid,
   output logic              a_arready,
   output logic [IDWID-1:0]  a_rid,
   output logic [DWID-1:0]   a_rdata,
   output logic [1:0]        a_rresp,
   output logic              a_rlast,
   output logic              a_rvalid,
   input  logic              a_rready,

   input  logic [IDWID-1:0]  b_arid,
   input  logic [AWID-1:0]   b_araddr,
   input  logic [7:0]        b_arlen,
   input  logic [2:0]        b_arsize,
   input  logic [EXTRAS-1:0] b_arextras,
   input  logic [1:0]        b_arburst,
   input  logic              b_arvalid,
   output logic              b_arready,
   output logic [IDWID-1:0]  b_rid,
   output logic [DWID-1:0]   b_rdata,
   output logic [1:0]        b_rresp,
   output logic              b_rlast,
   output logic              b_rvalid,
   input  logic              b_rready,

   input  logic [IDWID-1:0]  c_arid,
   input  logic [AWID-1:0]   c_araddr,
   input  logic [7:0]        c_arlen,
   input  logic [2:0]        c_arsize,
   input  logic [EXTRAS-1:0] c_arextras,
   input  logic [1:0]        c_arburst,
   input  logic              c_arvalid,
   output logic              c_arready,
   output logic [IDWID-1:0]  c_rid,
   output logic [DWID-1:0]   c_rdata,
   output logic [1:0]        c_rresp,
   output logic              c_rlast,
   output logic              c_rvalid,
   input  logic              c_rready,

   input  logic [IDWID-1:0]  d_arid,
   input  logic [AWID-1:0]   d_araddr,
   input  logic [7:0]        d_arlen,
   input  logic [2:0]        d_arsize,
   input  logic [EXTRAS-1:0] d_arextras,
   input  logic [1:0]        d_arburst,
   input  logic              d_arvalid,
   output logic              d_arready,
   output logic [IDWID-1:0]  d_rid,
   output logic [DWID-1:0]   d_rdata,
   output logic [1:0]        d_rresp,
   output logic              d_rlast,
   output logic              d_rvalid,
   input  logic              d_rready,

   output logic [IDWID-1:0]  arid,
   output logic [AWID-1:0]   araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [EXTRAS-1:0] arextras,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,

   input  logic [IDWID-1:0]  rid,
   input  logic [DWID-1:0]   rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,

   output logic              err_rlast,
   output logic [1:0]        gnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]        r_state;
   logic              r_en;
   logic [1:0]        r_gnt;
   logic [7:0]        r_cnt;
   logic              r_err;
   logic              r_arvalid;
   logic [IDWID-1:0]  r_arid;
   logic [AWID-1:0]   r_araddr;
   logic [7:0]        r_arlen;
   logic [2:0]        r_arsize;
   logic [EXTRAS-1:0] r_arextras;
   logic [1:0]        r_arburst;

   logic [3:0]        w_mArvalid;
   logic [3:0]        w_mRready;
   logic [IDWID-1:0]  w_mArid     [4];
   logic [AWID-1:0]   w_mAraddr   [4];
   logic [7:0]        w_mArlen    [4];
   logic [2:0]        w_mArsize   [4];
   logic [EXTRAS-1:0] w_mArextras [4];
   logic [1:0]        w_mArburst  [4];

   logic              w_found;
   logic [1:0]        w_winner;
   logic [1:0]        w_scan;
   logic [3:0]        w_arreadyVec;
   logic              w_arHs;
   logic              w_inData;
   logic              w_rready;
   logic              w_beat;
   logic [3:0]        w_rvalidVec;
   logic              w_lenErr;
   logic              w_idErr;

   // Gather the four master request channels into indexable arrays.
   assign w_mArvalid = {d_arvalid, c_arvalid, b_arvalid, a_arvalid};
   assign w_mRready  = {d_rready,  c_rready,  b_rready,  a_rready};

   assign w_mArid[0]     = a_arid;
   assign w_mArid[1]     = b_arid;
   assign w_mArid[2]     = c_arid;
   assign w_mArid[3]     = d_arid;
   assign w_mAraddr[0]   = a_araddr;
   assign w_mAraddr[1]   = b_araddr;
   assign w_mAraddr[2]   = c_araddr;
   assign w_mAraddr[3]   = d_araddr;
   assign w_mArlen[0]    = a_arlen;
   assign w_mArlen[1]    = b_arlen;
   assign w_mArlen[2]    = c_arlen;
   assign w_mArlen[3]    = d_arlen;
   assign w_mArsize[0]   = a_arsize;
   assign w_mArsize[1]   = b_arsize;
   assign w_mArsize[2]   = c_arsize;
   assign w_mArsize[3]   = d_arsize;
   assign w_mArextras[0] = a_arextras;
   assign w_mArextras[1] = b_arextras;
   assign w_mArextras[2] = c_arextras;
   assign w_mArextras[3] = d_arextras;
   assign w_mArburst[0]  = a_arburst;
   assign w_mArburst[1]  = b_arburst;
   assign w_mArburst[2]  = c_arburst;
   assign w_mArburst[3]  = d_arburst;

   // Round-robin pick: scan upward starting just past the last grant, so the
   // master served most recently is looked at last.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_gnt;
      w_scan   = r_gnt;
      for (int i = 0; i < 4; i++) begin
         w_scan = w_scan + 2'd1;
         if (!w_found && w_mArvalid[w_scan]) begin
            w_found  = 1'b1;
            w_winner = w_scan;
         end
      end
   end

   // arready only goes to the winner, which is by construction requesting,
   // so any asserted ready bit is also a completed master handshake.
   assign w_arreadyVec = (r_en && (r_state == S_IDLE) && w_found) ?
                         (4'b0001 << w_winner) : 4'b0000;
   assign w_arHs       = |w_arreadyVec;

   assign w_inData    = (r_state == S_DATA);
   assign w_rready    = w_inData & w_mRready[r_gnt];
   assign w_beat      = rvalid & w_rready;
   assign w_rvalidVec = (w_inData && rvalid) ? (4'b0001 << r_gnt) : 4'b0000;

   // The counter holds beats remaining after the current one, so it must be
   // zero exactly when the slave marks the last beat.
   assign w_lenErr = rlast ? (r_cnt != 8'd0) : (r_cnt == 8'd0);
   assign w_idErr  = (rid != r_arid);

   // Main sequencer: grant and capture in IDLE, hold the request in ADDR
   // until the slave takes it, then count beats in DATA until rlast.
   // r_en keeps the first post-reset cycle from granting anything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_en       <= 1'b0;
         r_gnt      <= 2'd3;
         r_cnt      <= 8'd0;
         r_err      <= 1'b0;
         r_arvalid  <= 1'b0;
         r_arid     <= '0;
         r_araddr   <= '0;
         r_arlen    <= '0;
         r_arsize   <= '0;
         r_arextras <= '0;
         r_arburst  <= '0;
      end else begin
         r_en <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_arHs) begin
                  r_arid     <= w_mArid[w_winner];
                  r_araddr   <= w_mAraddr[w_winner];
                  r_arlen    <= w_mArlen[w_winner];
                  r_arsize   <= w_mArsize[w_winner];
                  r_arextras <= w_mArextras[w_winner];
                  r_arburst  <= w_mArburst[w_winner];
                  r_gnt      <= w_winner;
                  r_cnt      <= w_mArlen[w_winner];
                  r_arvalid  <= 1'b1;
                  r_state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  r_cnt <= r_cnt - 8'd1;
                  if (w_lenErr || w_idErr) begin
                     r_err <= 1'b1;
                  end
                  if (rlast) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign arid      = r_arid;
   assign araddr    = r_araddr;
   assign arlen     = r_arlen;
   assign arsize    = r_arsize;
   assign arextras  = r_arextras;
   assign arburst   = r_arburst;
   assign arvalid   = r_arvalid;
   assign rready    = w_rready;
   assign err_rlast = r_err;
   assign gnt       = r_gnt;

   assign a_arready = w_arreadyVec[0];
   assign b_arready = w_arreadyVec[1];
   assign c_arready = w_arreadyVec[2];
   assign d_arready = w_arreadyVec[3];

   assign a_rvalid  = w_rvalidVec[0];
   assign b_rvalid  = w_rvalidVec[1];
   assign c_rvalid  = w_rvalidVec[2];
   assign d_rvalid  = w_rvalidVec[3];

   // R payload is broadcast; only the granted master sees rvalid.
   assign a_rid   = rid;
   assign b_rid   = rid;
   assign c_rid   = rid;
   assign d_rid   = rid;
   assign a_rdata = rdata;
   assign b_rdata = rdata;
   assign c_rdata = rdata;
   assign d_rdata = rdata;
   assign a_rresp = rresp;
   assign b_rresp = rresp;
   assign c_rresp = rresp;
   assign d_rresp = rresp;
   assign a_rlast = rlast;
   assign b_rlast = rlast;
   assign c_rlast = rlast;
   assign d_rlast = rlast;

endmodule

// File: tb/tb_axi_rd_4_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_4_arbiter
//
// Purpose:
//   Self-checking bench for axi_rd_4_arbiter. A table of per-cycle vectors
//   covers reset, a single burst and round-robin order; hand-written
//   sequences cover slave AR stalls, rready backpressure, rlast errors and
//   reset in the middle of a burst; a randomized run is compared against a
//   transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_axi_rd_4_arbiter;

   localparam int AWID   = 32;
   localparam int EXTRAS = 8;
   localparam int IDWID  = 4;
   localparam int DWID   = 64;

   logic              clk = 1'b0;
   logic              rst_n;

   logic [IDWID-1:0]  iArid     [4];
   logic [AWID-1:0]   iAraddr   [4];
   logic [7:0]        iArlen    [4];
   logic [2:0]        iArsize   [4];
   logic [EXTRAS-1:0] iArextras [4];
   logic [1:0]        iArburst  [4];
   logic [3:0]        iArvalid;
   logic [3:0]        iRready;

   logic              oArready [4];
   logic [IDWID-1:0]  oRid     [4];
   logic [DWID-1:0]   oRdata   [4];
   logic [1:0]        oRresp   [4];
   logic              oRlast   [4];
   logic              oRvalid  [4];

   logic [IDWID-1:0]  sArid;
   logic [AWID-1:0]   sAraddr;
   logic [7:0]        sArlen;
   logic [2:0]        sArsize;
   logic [EXTRAS-1:0] sArextras;
   logic [1:0]        sArburst;
   logic              sArvalid;
   logic              sArready;
   logic [IDWID-1:0]  sRid;
   logic [DWID-1:0]   sRdata;
   logic [1:0]        sRresp;
   logic              sRlast;
   logic              sRvalid;
   logic              sRready;
   logic              errRlast;
   logic [1:0]        gnt;

   logic [3:0]        oArreadyVec;
   logic [3:0]        oRvalidVec;

   int                nChecks = 0;
   int                nFails  = 0;
   string             curTag  = "";

   // Reference model state: a burst is either waiting for the slave to take
   // the address, streaming data, or absent.
   int                mGnt;
   bit                mEn;
   bit                mAddrPend;
   bit                mDataOn;
   bit                mErr;
   int                mLeft;
   logic [IDWID-1:0]  mId;
   logic [AWID-1:0]   mAddr;
   logic [7:0]        mLen;
   logic [2:0]        mSize;
   logic [EXTRAS-1:0] mExtras;
   logic [1:0]        mBurst;

   typedef struct {
      logic        rstn;
      logic [3:0]  arv;
      logic [7:0]  arlen;
      logic        arready;
      logic        rvalid;
      logic        rlast;
      logic [3:0]  rid;
      logic [3:0]  rrdy;
      logic [3:0]  eArready;
      logic        eArvalid;
      logic [31:0] eAraddr;
      logic [3:0]  eRvalid;
      logic        eRready;
      logic [1:0]  eGnt;
      logic        eErr;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   assign oArreadyVec = {oArready[3], oArready[2], oArready[1], oArready[0]};
   assign oRvalidVec  = {oRvalid[3], oRvalid[2], oRvalid[1], oRvalid[0]};

   axi_rd_4_arbiter #(
      .AWID(AWID), .EXTRAS(EXTRAS), .IDWID(IDWID), .DWID(DWID)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .a_arid(iArid[0]), .a_araddr(iAraddr[0]), .a_arlen(iArlen[0]),
      .a_arsize(iArsize[0]), .a_arextras(iArextras[0]), .a_arburst(iArburst[0]),
      .a_arvalid(iArvalid[0]), .a_arready(oArready[0]), .a_rid(oRid[0]),
      .a_rdata(oRdata[0]), .a_rresp(oRresp[0]), .a_rlast(oRlast[0]),
      .a_rvalid(oRvalid[0]), .a_rready(iRready[0]),
      .b_arid(iArid[1]), .b_araddr(iAraddr[1]), .b_arlen(iArlen[1]),
      .b_arsize(iArsize[1]), .b_arextras(iArextras[1]), .b_arburst(iArburst[1]),
      .b_arvalid(iArvalid[1]), .b_arready(oArready[1]), .b_rid(oRid[1]),
      .b_rdata(oRdata[1]), .b_rresp(oRresp[1]), .b_rlast(oRlast[1]),
      .b_rvalid(oRvalid[1]), .b_rready(iRready[1]),
      .c_arid(iArid[2]), .c_araddr(iAraddr[2]), .c_arlen(iArlen[2]),
      .c_arsize(iArsize[2]), .c_arextras(iArextras[2]), .c_arburst(iArburst[2]),
      .c_arvalid(iArvalid[2]), .c_arready(oArready[2]), .c_rid(oRid[2]),
      .c_rdata(oRdata[2]), .c_rresp(oRresp[2]), .c_rlast(oRlast[2]),
      .c_rvalid(oRvalid[2]), .c_rready(iRready[2]),
      .d_arid(iArid[3]), .d_araddr(iAraddr[3]), .d_arlen(iArlen[3]),
      .d_arsize(iArsize[3]), .d_arextras(iArextras[3]), .d_arburst(iArburst[3]),
      .d_arvalid(iArvalid[3]), .d_arready(oArready[3]), .d_rid(oRid[3]),
      .d_rdata(oRdata[3]), .d_rresp(oRresp[3]), .d_rlast(oRlast[3]),
      .d_rvalid(oRvalid[3]), .d_rready(iRready[3]),
      .arid(sArid), .araddr(sAraddr), .arlen(sArlen), .arsize(sArsize),
      .arextras(sArextras), .arburst(sArburst), .arvalid(sArvalid),
      .arready(sArready),
      .rid(sRid), .rdata(sRdata), .rresp(sRresp), .rlast(sRlast),
      .rvalid(sRvalid), .rready(sRready),
      .err_rlast(errRlast), .gnt(gnt)
   );

   function automatic vec_t mk(
      input logic rstn, input logic [3:0] arv, input logic [7:0] arlen,
      input logic arready, input logic rvalid, input logic rlast,
      input logic [3:0] rid, input logic [3:0] rrdy,
      input logic [3:0] eArready, input logic eArvalid, input logic [31:0] eAraddr,
      input logic [3:0] eRvalid, input logic eRready, input logic [1:0] eGnt,
      input logic eErr);
      vec_t v;
      v.rstn = rstn; v.arv = arv; v.arlen = arlen; v.arready = arready;
      v.rvalid = rvalid; v.rlast = rlast; v.rid = rid; v.rrdy = rrdy;
      v.eArready = eArready; v.eArvalid = eArvalid; v.eAraddr = eAraddr;
      v.eRvalid = eRvalid; v.eRready = eRready; v.eGnt = eGnt; v.eErr = eErr;
      return v;
   endfunction

   task automatic checkField(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", curTag, name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst_n    = v.rstn;
      iArvalid = v.arv;
      for (int x = 0; x < 4; x++) iArlen[x] = v.arlen;
      sArready = v.arready;
      sRvalid  = v.rvalid;
      sRlast   = v.rlast;
      sRid     = v.rid;
      iRready  = v.rrdy;
      sRdata   = {$urandom, $urandom};
      sRresp   = 2'($urandom);
   endtask

   task automatic checkOutput(input vec_t v);
      checkField("arready", 64'(oArreadyVec), 64'(v.eArready));
      checkField("arvalid", 64'(sArvalid), 64'(v.eArvalid));
      checkField("araddr", 64'(sAraddr), 64'(v.eAraddr));
      checkField("rvalid", 64'(oRvalidVec), 64'(v.eRvalid));
      checkField("rready", 64'(sRready), 64'(v.eRready));
      checkField("gnt", 64'(gnt), 64'(v.eGnt));
      checkField("err_rlast", 64'(errRlast), 64'(v.eErr));
      for (int x = 0; x < 4; x++) begin
         if (v.eRvalid[x]) begin
            checkField("rdata", oRdata[x], sRdata);
            checkField("rlast", 64'(oRlast[x]), 64'(sRlast));
            checkField("rid", 64'(oRid[x]), 64'(sRid));
            checkField("rresp", 64'(oRresp[x]), 64'(sRresp));
         end
      end
   endtask

   task automatic runVec(input vec_t v, input string tag);
      curTag = tag;
      applyStimulus(v);
      #4;
      checkOutput(v);
      @(posedge clk);
      #1;
   endtask

   // First requester at or after last grant + 1, wrapping modulo 4.
   function automatic int modelWinner();
      for (int k = 1; k <= 4; k++) begin
         if (iArvalid[(mGnt + k) % 4]) return (mGnt + k) % 4;
      end
      return -1;
   endfunction

   task automatic modelReset();
      mGnt = 3; mEn = 0; mAddrPend = 0; mDataOn = 0; mErr = 0; mLeft = 0;
      mId = '0; mAddr = '0; mLen = '0; mSize = '0; mExtras = '0; mBurst = '0;
   endtask

   initial begin
      logic [1:0] ids [4];
      int         w;
      logic [3:0] eArr;
      logic [3:0] eRv;
      logic       eRr;

      rst_n = 1'b0;
      iArvalid = '0; iRready = '0;
      sArready = 0; sRvalid = 0; sRlast = 0; sRid = '0; sRdata = '0; sRresp = '0;
      for (int x = 0; x < 4; x++) begin
         iArid[x]     = IDWID'(x + 5);
         iAraddr[x]   = AWID'((x + 1) * 32'h1000);
         iArlen[x]    = 8'd0;
         iArsize[x]   = 3'd3;
         iArburst[x]  = 2'd1;
         iArextras[x] = EXTRAS'(x);
      end
      ids = '{2'd0, 2'd1, 2'd2, 2'd3};

      // Single burst from a: reset, first post-reset cycle grants nothing,
      // then grant, address phase, four beats, idle with stray rvalid.
      tbl.push_back(mk(1'b0, 4'b0000, 8'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0001, 8'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0001, 8'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0001, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 8'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b1, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b0));
      for (int b = 0; b < 3; b++)
         tbl.push_back(mk(1'b1, 4'b0000, 8'd3, 1'b0, 1'b1, 1'b0, 4'd5, 4'hF, 4'b0000, 1'b0, 32'h1000, 4'b0001, 1'b1, 2'd0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 8'd3, 1'b0, 1'b1, 1'b1, 4'd5, 4'hF, 4'b0000, 1'b0, 32'h1000, 4'b0001, 1'b1, 2'd0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 8'd3, 1'b0, 1'b1, 1'b0, 4'd5, 4'hF, 4'b0000, 1'b0, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b0));

      // All four requesting with single-beat bursts after a reset: a,b,c,d,a.
      tbl.push_back(mk(1'b0, 4'hF, 8'd0, 1'b1, 1'b1, 1'b1, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0));
      tbl.push_back(mk(1'b1, 4'hF, 8'd0, 1'b1, 1'b1, 1'b1, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0));
      for (int k = 0; k < 5; k++) begin
         logic [1:0]  wn;
         logic [1:0]  pv;
         logic [31:0] prevAddr;
         logic [31:0] curAddr;
         wn = ids[k % 4];
         pv = (k == 0) ? 2'd3 : ids[(k - 1) % 4];
         prevAddr = (k == 0) ? 32'h0 : 32'(({30'd0, pv} + 32'd1) * 32'h1000);
         curAddr  = 32'(({30'd0, wn} + 32'd1) * 32'h1000);
         tbl.push_back(mk(1'b1, 4'hF, 8'd0, 1'b1, 1'b1, 1'b1, 4'(wn + 2'd1) + 4'd4, 4'hF,
                          4'b0001 << wn, 1'b0, prevAddr, 4'b0000, 1'b0, pv, 1'b0));
         tbl.push_back(mk(1'b1, 4'hF, 8'd0, 1'b1, 1'b1, 1'b1, 4'(wn + 2'd1) + 4'd4, 4'hF,
                          4'b0000, 1'b1, curAddr, 4'b0000, 1'b0, wn, 1'b0));
         tbl.push_back(mk(1'b1, 4'hF, 8'd0, 1'b1, 1'b1, 1'b1, 4'(wn + 2'd1) + 4'd4, 4'hF,
                          4'b0000, 1'b0, curAddr, 4'b0001 << wn, 1'b1, wn, 1'b0));
      end

      @(posedge clk);
      #1;
      $display("[TB] table vectors: %0d", tbl.size());
      for (int i = 0; i < tbl.size(); i++) runVec(tbl[i], $sformatf("table%0d", i));

      // Slave holds arready low while b is granted; others keep requesting.
      runVec(mk(1'b1, 4'b0010, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0010, 1'b0, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b0), "stall");
      for (int i = 0; i < 5; i++)
         runVec(mk(1'b1, 4'b1101, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b1, 32'h2000, 4'b0000, 1'b0, 2'd1, 1'b0), "stall");
      runVec(mk(1'b1, 4'b1101, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b1, 32'h2000, 4'b0000, 1'b0, 2'd1, 1'b0), "stall");
      runVec(mk(1'b1, 4'b1101, 8'd0, 1'b0, 1'b1, 1'b1, 4'd6, 4'hF, 4'b0000, 1'b0, 32'h2000, 4'b0010, 1'b1, 2'd1, 1'b0), "stall");
      runVec(mk(1'b1, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h2000, 4'b0000, 1'b0, 2'd1, 1'b0), "stall");

      // rready backpressure on c: a stalled beat must not count.
      runVec(mk(1'b1, 4'b0100, 8'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0100, 1'b0, 32'h2000, 4'b0000, 1'b0, 2'd1, 1'b0), "backpr");
      runVec(mk(1'b1, 4'b0000, 8'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b1, 32'h3000, 4'b0000, 1'b0, 2'd2, 1'b0), "backpr");
      runVec(mk(1'b1, 4'b0000, 8'd1, 1'b0, 1'b1, 1'b0, 4'd7, 4'b0100, 4'b0000, 1'b0, 32'h3000, 4'b0100, 1'b1, 2'd2, 1'b0), "backpr");
      runVec(mk(1'b1, 4'b0000, 8'd1, 1'b0, 1'b1, 1'b1, 4'd7, 4'b1011, 4'b0000, 1'b0, 32'h3000, 4'b0100, 1'b0, 2'd2, 1'b0), "backpr");
      runVec(mk(1'b1, 4'b0000, 8'd1, 1'b0, 1'b1, 1'b1, 4'd7, 4'b0100, 4'b0000, 1'b0, 32'h3000, 4'b0100, 1'b1, 2'd2, 1'b0), "backpr");
      runVec(mk(1'b1, 4'b0000, 8'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h3000, 4'b0000, 1'b0, 2'd2, 1'b0), "backpr");

      // Early rlast on d (arlen=2, rlast on beat 2): sticky error, next burst served.
      runVec(mk(1'b1, 4'b1000, 8'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b1000, 1'b0, 32'h3000, 4'b0000, 1'b0, 2'd2, 1'b0), "early");
      runVec(mk(1'b1, 4'b0000, 8'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b1, 32'h4000, 4'b0000, 1'b0, 2'd3, 1'b0), "early");
      runVec(mk(1'b1, 4'b0000, 8'd2, 1'b0, 1'b1, 1'b0, 4'd8, 4'hF, 4'b0000, 1'b0, 32'h4000, 4'b1000, 1'b1, 2'd3, 1'b0), "early");
      runVec(mk(1'b1, 4'b0000, 8'd2, 1'b0, 1'b1, 1'b1, 4'd8, 4'hF, 4'b0000, 1'b0, 32'h4000, 4'b1000, 1'b1, 2'd3, 1'b0), "early");
      runVec(mk(1'b1, 4'b0001, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0001, 1'b0, 32'h4000, 4'b0000, 1'b0, 2'd3, 1'b1), "early");
      runVec(mk(1'b1, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b1, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b1), "early");
      runVec(mk(1'b1, 4'b0000, 8'd0, 1'b0, 1'b1, 1'b1, 4'd5, 4'hF, 4'b0000, 1'b0, 32'h1000, 4'b0001, 1'b1, 2'd0, 1'b1), "early");
      runVec(mk(1'b1, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b1), "early");

      // Reset during d's data phase, then a/d contend (a wins), then a
      // correctly sized burst answered with the wrong rid.
      runVec(mk(1'b1, 4'b1000, 8'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b1000, 1'b0, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b1), "midrst");
      runVec(mk(1'b1, 4'b0000, 8'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b1, 32'h4000, 4'b0000, 1'b0, 2'd3, 1'b1), "midrst");
      runVec(mk(1'b1, 4'b0000, 8'd3, 1'b0, 1'b1, 1'b0, 4'd8, 4'hF, 4'b0000, 1'b0, 32'h4000, 4'b1000, 1'b1, 2'd3, 1'b1), "midrst");
      runVec(mk(1'b0, 4'b1001, 8'd3, 1'b0, 1'b1, 1'b0, 4'd8, 4'hF, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0), "midrst");
      runVec(mk(1'b1, 4'b1001, 8'd0, 1'b0, 1'b1, 1'b0, 4'd8, 4'hF, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0), "midrst");
      runVec(mk(1'b1, 4'b1001, 8'd0, 1'b0, 1'b1, 1'b0, 4'd8, 4'hF, 4'b0001, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd3, 1'b0), "midrst");
      runVec(mk(1'b1, 4'b0000, 8'd0, 1'b1, 1'b1, 1'b0, 4'd8, 4'hF, 4'b0000, 1'b1, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b0), "midrst");
      runVec(mk(1'b1, 4'b0000, 8'd0, 1'b0, 1'b1, 1'b1, 4'd8, 4'hF, 4'b0000, 1'b0, 32'h1000, 4'b0001, 1'b1, 2'd0, 1'b0), "midrst");
      runVec(mk(1'b1, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF, 4'b0000, 1'b0, 32'h1000, 4'b0000, 1'b0, 2'd0, 1'b1), "midrst");

      // Randomized traffic against the reference model, well-behaved slave.
      curTag = "random";
      rst_n = 1'b0;
      #4;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int x = 0; x < 4; x++) begin
            iArvalid[x]  = 1'($urandom_range(0, 1));
            iArid[x]     = IDWID'($urandom);
            iAraddr[x]   = AWID'($urandom);
            iArlen[x]    = 8'($urandom_range(0, 3));
            iArsize[x]   = 3'($urandom);
            iArburst[x]  = 2'($urandom);
            iArextras[x] = EXTRAS'($urandom);
            iRready[x]   = ($urandom_range(0, 9) < 7);
         end
         sArready = ($urandom_range(0, 9) < 6);
         sRvalid  = ($urandom_range(0, 9) < 6);
         sRdata   = {$urandom, $urandom};
         sRresp   = 2'($urandom);
         if (mDataOn) begin
            sRid   = mId;
            sRlast = (mLeft == 1);
         end else begin
            sRid   = IDWID'($urandom);
            sRlast = 1'($urandom);
         end
         #4;
         w    = modelWinner();
         eArr = (mEn && !mAddrPend && !mDataOn && w >= 0) ? (4'b0001 << w) : 4'b0000;
         eRr  = mDataOn && iRready[mGnt];
         eRv  = (mDataOn && sRvalid) ? (4'b0001 << mGnt) : 4'b0000;
         checkField("arready", 64'(oArreadyVec), 64'(eArr));
         checkField("arvalid", 64'(sArvalid), 64'(mAddrPend));
         checkField("arid", 64'(sArid), 64'(mId));
         checkField("araddr", 64'(sAraddr), 64'(mAddr));
         checkField("arlen", 64'(sArlen), 64'(mLen));
         checkField("arsize", 64'(sArsize), 64'(mSize));
         checkField("arburst", 64'(sArburst), 64'(mBurst));
         checkField("arextras", 64'(sArextras), 64'(mExtras));
         checkField("rvalid", 64'(oRvalidVec), 64'(eRv));
         checkField("rready", 64'(sRready), 64'(eRr));
         checkField("gnt", 64'(gnt), 64'(mGnt));
         checkField("err_rlast", 64'(errRlast), 64'(mErr));
         @(posedge clk);
         if (eArr != 4'b0000) begin
            mGnt = w; mAddrPend = 1; mLeft = int'(iArlen[w]) + 1;
            mId = iArid[w]; mAddr = iAraddr[w]; mLen = iArlen[w];
            mSize = iArsize[w]; mBurst = iArburst[w]; mExtras = iArextras[w];
         end else if (mAddrPend && sArready) begin
            mAddrPend = 0; mDataOn = 1;
         end else if (mDataOn && sRvalid && iRready[mGnt]) begin
            if ((sRlast != (mLeft == 1)) || (sRid != mId)) mErr = 1;
            mLeft = mLeft - 1;
            if (sRlast) mDataOn = 0;
         end
         mEn = 1;
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
